// File: rtl/tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_1to4
// Purpose  : Receive end of a 4-slot TDM link. Aligns to the frame marker,
//            steers each serial sample into its lane register, presents the
//            complete 4-lane word with a one-cycle valid strobe and flags
//            loss of frame alignment.
// Ports    : clk, rst      - rising-edge clock, synchronous active-high reset
//            in[W]         - serial sample for the current slot
//            in_valid      - in carries a sample this cycle
//            frame_sync    - current sample is slot 0 (ignored if !in_valid)
//            out[4W]       - lane word, lane k at out[k*W +: W] (registered)
//            out_valid     - one-cycle strobe when out is updated
//            slot[2]       - index of the next expected slot
//            locked        - high while aligned (state SYNC)
//            sync_err      - one-cycle strobe on an alignment error
//            err_cnt[8]    - saturating error count
// Config   : `define TDM_DEMUX_ERR_CNT_EN builds the error counter;
//            otherwise err_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_1to4 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in,
    input  logic           in_valid,
    input  logic           frame_sync,
    output logic [4*W-1:0] out,
    output logic           out_valid,
    output logic [1:0]     slot,
    output logic           locked,
    output logic           sync_err,
    output logic [7:0]     err_cnt
);

    localparam logic [0:0] c_HUNT = 1'b0;
    localparam logic [0:0] c_SYNC = 1'b1;

    logic [0:0]     r_state;
    logic [1:0]     r_slot;
    logic [W-1:0]   r_lane0;
    logic [W-1:0]   r_lane1;
    logic [W-1:0]   r_lane2;
    logic [4*W-1:0] r_out;
    logic           r_out_valid;
    logic           r_sync_err;

    // Alignment errors: a marker arriving mid-frame, or a slot-0 sample
    // arriving without one. Shared by the FSM and the error counter so both
    // update on the same edge.
    logic w_premature;
    logic w_missing;
    logic w_err;

    assign w_premature = in_valid && (r_state == c_SYNC) && frame_sync && (r_slot != 2'd0);
    assign w_missing   = in_valid && (r_state == c_SYNC) && !frame_sync && (r_slot == 2'd0);
    assign w_err       = w_premature || w_missing;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_HUNT;
            r_slot      <= 2'd0;
            r_lane0     <= '0;
            r_lane1     <= '0;
            r_lane2     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_sync_err  <= w_err;
            if (in_valid) begin
                if (r_state == c_HUNT) begin
                    if (frame_sync) begin
                        r_lane0 <= in;
                        r_slot  <= 2'd1;
                        r_state <= c_SYNC;
                    end
                end else if (frame_sync) begin
                    // Marker always restarts the frame; any partial lanes are
                    // dropped so a stale sample can never leak into out.
                    r_lane0 <= in;
                    r_lane1 <= '0;
                    r_lane2 <= '0;
                    r_slot  <= 2'd1;
                end else begin
                    case (r_slot)
                        2'd0: begin
                            r_state <= c_HUNT;
                            r_slot  <= 2'd0;
                            r_lane0 <= '0;
                            r_lane1 <= '0;
                            r_lane2 <= '0;
                        end
                        2'd1: begin
                            r_lane1 <= in;
                            r_slot  <= 2'd2;
                        end
                        2'd2: begin
                            r_lane2 <= in;
                            r_slot  <= 2'd3;
                        end
                        default: begin
                            r_out       <= {in, r_lane2, r_lane1, r_lane0};
                            r_out_valid <= 1'b1;
                            r_slot      <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign slot      = r_slot;
    assign locked    = (r_state == c_SYNC);
    assign sync_err  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_1to4
// Purpose  : Self-checking bench for tdm_demux_1to4 (W=1 and W=8 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_1to4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // W=1 instance
    logic       rst1, vin1, fs1;
    logic [0:0] din1;
    logic [3:0] out1;
    logic       ov1, lk1, err1;
    logic [1:0] slot1;
    logic [7:0] cnt1;

    // W=8 instance
    logic        rst8, vin8, fs8;
    logic [7:0]  din8;
    logic [31:0] out8;
    logic        ov8, lk8, err8;
    logic [1:0]  slot8;
    logic [7:0]  cnt8;

    tdm_demux_1to4 #(.W(1)) u1 (
        .clk(clk), .rst(rst1), .in(din1), .in_valid(vin1), .frame_sync(fs1),
        .out(out1), .out_valid(ov1), .slot(slot1), .locked(lk1),
        .sync_err(err1), .err_cnt(cnt1)
    );

    tdm_demux_1to4 #(.W(8)) u8 (
        .clk(clk), .rst(rst8), .in(din8), .in_valid(vin8), .frame_sync(fs8),
        .out(out8), .out_valid(ov8), .slot(slot8), .locked(lk8),
        .sync_err(err8), .err_cnt(cnt8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected err_cnt depends on whether the counter is built.
    function automatic logic [7:0] ecnt(input int c);
`ifdef TDM_DEMUX_ERR_CNT_EN
        return (c > 255) ? 8'd255 : c[7:0];
`else
        return 8'd0;
`endif
    endfunction

    typedef struct {
        logic       rst, vin, fs, din;
        logic [3:0] out;
        logic       ov;
        logic [1:0] slot;
        logic       lk, err;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic f, input logic d,
                       input logic [3:0] o, input logic ov, input logic [1:0] s,
                       input logic lk, input logic e, input int c);
        vec_t x;
        x.rst = r; x.vin = v; x.fs = f; x.din = d;
        x.out = o; x.ov = ov; x.slot = s; x.lk = lk; x.err = e; x.cnt = c;
        vecs.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst1 = 1'b1; vin1 = 1'b0; fs1 = 1'b0; din1 = 1'b0;
        rst8 = 1'b1; vin8 = 1'b0; fs8 = 1'b0; din8 = 8'h00;

        //   rst vin fs din | out   ov slot lk err cnt
        // reset
        add(1, 0, 0, 0,   4'h0, 0, 0, 0, 0, 0);
        // basic frame 1,0,1,1
        add(0, 1, 1, 1,   4'h0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0,   4'h0, 0, 2, 1, 0, 0);
        add(0, 1, 0, 1,   4'h0, 0, 3, 1, 0, 0);
        add(0, 1, 0, 1,   4'hD, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0,   4'hD, 0, 0, 1, 0, 0);
        // hunt discard
        add(1, 0, 0, 0,   4'h0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   4'h0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0,   4'h0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1,   4'h0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0,   4'h0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 1,   4'h0, 0, 2, 1, 0, 0);
        add(0, 1, 0, 1,   4'h0, 0, 3, 1, 0, 0);
        add(0, 1, 0, 0,   4'h6, 1, 0, 1, 0, 0);
        // gapped frame 1,1,0,0 with two idle cycles between samples
        add(0, 1, 1, 1,   4'h6, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0,   4'h6, 0, 1, 1, 0, 0);
        add(0, 0, 1, 0,   4'h6, 0, 1, 1, 0, 0);
        add(0, 1, 0, 1,   4'h6, 0, 2, 1, 0, 0);
        add(0, 0, 0, 1,   4'h6, 0, 2, 1, 0, 0);
        add(0, 0, 0, 0,   4'h6, 0, 2, 1, 0, 0);
        add(0, 1, 0, 0,   4'h6, 0, 3, 1, 0, 0);
        add(0, 0, 1, 1,   4'h6, 0, 3, 1, 0, 0);
        add(0, 0, 0, 0,   4'h6, 0, 3, 1, 0, 0);
        add(0, 1, 0, 0,   4'h3, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0,   4'h3, 0, 0, 1, 0, 0);
        // premature marker on 3rd sample, then frame completes
        add(0, 1, 1, 1,   4'h3, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0,   4'h3, 0, 2, 1, 0, 0);
        add(0, 1, 1, 1,   4'h3, 0, 1, 1, 1, 1);
        add(0, 1, 0, 0,   4'h3, 0, 2, 1, 0, 1);
        add(0, 1, 0, 1,   4'h3, 0, 3, 1, 0, 1);
        add(0, 1, 0, 1,   4'hD, 1, 0, 1, 0, 1);
        // missing marker
        add(0, 1, 0, 0,   4'hD, 0, 0, 0, 1, 2);
        add(0, 0, 0, 0,   4'hD, 0, 0, 0, 0, 2);
        // reset mid-frame (sample in reset cycle ignored), then 1,0,0,1
        add(0, 1, 1, 1,   4'hD, 0, 1, 1, 0, 2);
        add(0, 1, 0, 1,   4'hD, 0, 2, 1, 0, 2);
        add(1, 1, 1, 1,   4'h0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1,   4'h0, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0,   4'h0, 0, 2, 1, 0, 0);
        add(0, 1, 0, 0,   4'h0, 0, 3, 1, 0, 0);
        add(0, 1, 0, 1,   4'h9, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0,   4'h9, 0, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            rst1 = vecs[i].rst; vin1 = vecs[i].vin; fs1 = vecs[i].fs; din1 = vecs[i].din;
            tick();
            chk($sformatf("v%0d.out", i),      64'(out1),  64'(vecs[i].out));
            chk($sformatf("v%0d.valid", i),    64'(ov1),   64'(vecs[i].ov));
            chk($sformatf("v%0d.slot", i),     64'(slot1), 64'(vecs[i].slot));
            chk($sformatf("v%0d.locked", i),   64'(lk1),   64'(vecs[i].lk));
            chk($sformatf("v%0d.sync_err", i), 64'(err1),  64'(vecs[i].err));
            chk($sformatf("v%0d.err_cnt", i),  64'(cnt1),  64'(ecnt(vecs[i].cnt)));
        end

        // Saturation: marker held on every valid cycle; first one locks,
        // each following one is a premature-marker error.
        rst1 = 1'b1; vin1 = 1'b0; fs1 = 1'b0; din1 = 1'b0;
        tick();
        rst1 = 1'b0; vin1 = 1'b1; fs1 = 1'b1;
        for (int k = 0; k < 301; k++) begin
            tick();
            if (k == 5) begin
                chk("sat.err_cnt_5", 64'(cnt1), 64'(ecnt(5)));
                chk("sat.sync_err_5", 64'(err1), 64'd1);
            end
        end
        chk("sat.err_cnt", 64'(cnt1), 64'(ecnt(300)));
        chk("sat.locked",  64'(lk1),  64'd1);
        chk("sat.slot",    64'(slot1), 64'd1);
        vin1 = 1'b0; fs1 = 1'b0;
        tick();
        chk("sat.err_drop", 64'(err1), 64'd0);
        chk("sat.hold",     64'(cnt1), 64'(ecnt(300)));
        rst1 = 1'b1;
        tick();
        chk("sat.clear", 64'(cnt1), 64'd0);
        rst1 = 1'b0;

        // W=8 back-to-back frames at full rate
        tick();
        rst8 = 1'b0; vin8 = 1'b1;
        begin
            logic [7:0] seq [8];
            seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
            for (int k = 0; k < 8; k++) begin
                din8 = seq[k];
                fs8  = (k == 0 || k == 4);
                tick();
                if (k == 3) begin
                    chk("w8.out1", 64'(out8), 64'h44332211);
                    chk("w8.ov1",  64'(ov8),  64'd1);
                end else if (k == 7) begin
                    chk("w8.out2", 64'(out8), 64'hD0C0B0A0);
                    chk("w8.ov2",  64'(ov8),  64'd1);
                end else begin
                    chk($sformatf("w8.ov_gap%0d", k), 64'(ov8), 64'd0);
                    chk($sformatf("w8.err%0d", k),    64'(err8), 64'd0);
                end
            end
        end
        vin8 = 1'b0; fs8 = 1'b0;
        tick();
        chk("w8.ov_end",  64'(ov8),  64'd0);
        chk("w8.hold",    64'(out8), 64'hD0C0B0A0);
        chk("w8.locked",  64'(lk8),  64'd1);
        chk("w8.slot",    64'(slot8), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_demux_1to4.md
# tdm_demux_1to4

Receive end of the 4-slot time-division link. The transmit end drives one lane per cycle through a 4-to-1 select with a rotating slot counter. This block accepts the serialized stream, aligns to the frame marker, and steers each sample back into its own lane register. It presents a complete 4-lane word with a one-cycle valid strobe, and it detects and reports loss of frame alignment.

## Interface
Parameters:
- `W`, default 1: width of one lane sample.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in`, input, W: serial sample for the current slot.
- `in_valid`, input, 1: `in` carries a sample this cycle.
- `frame_sync`, input, 1: qualifies the current sample as slot 0. Ignored when `in_valid`=0.
- `out`, output, 4*W: lane word. Lane k is at `out[k*W +: W]`. Registered.
- `out_valid`, output, 1: one-cycle strobe when `out` is updated.
- `slot`, output, 2: index of the next expected slot.
- `locked`, output, 1: high in state SYNC.
- `sync_err`, output, 1: one-cycle strobe on an alignment error.
- `err_cnt`, output, 8: alignment error count. Present only with the macro in Configuration.

## Operation
- Reset values: `out`=0, `out_valid`=0, `slot`=0, `locked`=0, `sync_err`=0, `err_cnt`=0, state HUNT, partial-lane registers=0.
- A sample is accepted when `in_valid`=1. Cycles with `in_valid`=0 change no state except clearing the strobes.
- HUNT:
  - Accepted samples with `frame_sync`=0 are discarded.
  - An accepted sample with `frame_sync`=1 is stored as lane 0, sets `slot`=1 and moves the block to SYNC.
- SYNC, accepted sample with `slot`=1 or 2:
  - `frame_sync`=0: store the sample in lane `slot` and increment `slot`.
  - `frame_sync`=1: premature marker. Pulse `sync_err`, discard the partial frame, store the sample as lane 0, set `slot`=1, stay in SYNC.
- SYNC, accepted sample with `slot`=3:
  - `frame_sync`=0: the frame is complete. Load `out` with {sample, lane2, lane1, lane0}, pulse `out_valid`, set `slot`=0.
  - `frame_sync`=1: premature marker, handled as above. `out` is not updated.
- SYNC, accepted sample with `slot`=0:
  - `frame_sync`=1: store as lane 0, set `slot`=1.
  - `frame_sync`=0: missing marker. Pulse `sync_err`, discard the sample, go to HUNT, set `slot`=0.
- `out` holds its last complete word between updates, in HUNT, and after errors. It is never partially updated.
- `slot` wraps 3→0 only on frame completion.
- `rst` asserted mid-frame: all state returns to reset values on that edge and the partial frame is lost. Any sample presented in the same cycle as `rst` is ignored.

## Timing
- Latency: `out` and `out_valid` change on the clock edge that accepts the slot-3 sample, so both are visible in the following cycle.
- `out_valid` and `sync_err` are single-cycle pulses. They are never high in the same cycle.
- Back-to-back frames at full rate, with `in_valid` held high, produce `out_valid` every 4th cycle with no gaps.
- `locked` rises in the cycle after the first accepted `frame_sync` in HUNT. It falls in the cycle after a missing-marker error.
- Throughput: one sample per cycle. There is no backpressure, and the block always accepts.

## Configuration
- Macro `TDM_DEMUX_ERR_CNT_EN`.
- Defined:
  - `err_cnt` increments by 1 on every `sync_err` pulse and saturates at 255.
  - `err_cnt` is cleared only by `rst`.
  - The update is visible in the same cycle as the `sync_err` pulse.
- Undefined: `err_cnt` is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Basic frame, W=1:
  - Stimulus: after reset, valid samples 1,0,1,1 with `frame_sync` on the first sample.
  - Expected: `out`=4'b1101, `out_valid` for exactly 1 cycle, `locked`=1, `slot`=0.
- Hunt discard:
  - Stimulus: three valid samples without `frame_sync`, then frame 0,1,1,0 with the marker on the first sample.
  - Expected: no `out_valid` for the first three samples, then `out`=4'b0110.
- Gapped input:
  - Stimulus: frame 1,1,0,0 with `in_valid` low for 2 cycles between each sample.
  - Expected: `out`=4'b0011 one cycle after the last sample; `out` unchanged before that.
- Alignment errors:
  - Premature marker stimulus: `frame_sync` on the 3rd sample.
  - Premature marker expected: `sync_err` pulse, `out` unchanged, `slot`=1, `locked`=1.
  - Missing marker stimulus: a full frame, then a slot-0 sample without the marker.
  - Missing marker expected: `sync_err` pulse, `locked`=0.
  - With `TDM_DEMUX_ERR_CNT_EN`: `err_cnt`=2 after both errors.
  - Saturation: 300 errors give `err_cnt`=255.
- Reset mid-frame:
  - Stimulus: assert `rst` after 2 samples of a frame, then send a clean frame 1,0,0,1.
  - Expected: all outputs 0 in the cycle after `rst`, then `out`=4'b1001.
- Wide lanes, W=8, back-to-back:
  - Stimulus: two continuous frames 0x11,0x22,0x33,0x44 then 0xA0,0xB0,0xC0,0xD0.
  - Expected: `out`=0x44332211, then 0xD0C0B0A0 exactly 4 cycles later.
